// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel clock-enable divider, beam position counters and
// registered sync/blank/data-enable decode with frame counter and line interrupt.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CE_DIV   = 2,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [CW-1:0] irq_line,
    output logic          ce_pix,
    output logic          hs,
    output logic          vs,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic          frame_start,
    output logic          line_irq,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
        $error("video_timing_gen: horizontal geometry parameters must be >= 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
        $error("video_timing_gen: vertical geometry parameters must be >= 1");
    end
    if (CE_DIV < 1) begin : g_bad_div
        $error("video_timing_gen: CE_DIV must be >= 1");
    end
    if (CW < 2 || CW > 30 || H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_cw
        $error("video_timing_gen: H_TOTAL and V_TOTAL must fit below 2^CW");
    end

    localparam logic [CW-1:0] H_ACT_C   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYN0_C  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYN1_C  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST_C  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_C   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYN0_C  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYN1_C  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST_C  = CW'(V_TOTAL - 1);
    localparam logic [DW-1:0] DIV_TOP_C = DW'(CE_DIV - 1);

    logic [DW-1:0] div;
    logic [CW-1:0] hpos;
    logic [CW-1:0] vpos;
    logic          started;

    logic tick;
    logic hblank_d;
    logic vblank_d;
    logic hs_on;
    logic vs_on;
    logic at_origin;

    assign tick      = enable && (div == DIV_TOP_C);
    assign hblank_d  = (hpos >= H_ACT_C);
    assign vblank_d  = (vpos >= V_ACT_C);
    assign hs_on     = (hpos >= H_SYN0_C) && (hpos < H_SYN1_C);
    assign vs_on     = (vpos >= V_SYN0_C) && (vpos < V_SYN1_C);
    assign at_origin = (hpos == '0) && (vpos == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div         <= '0;
            hpos        <= '0;
            vpos        <= '0;
            started     <= 1'b0;
            ce_pix      <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            de          <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
            line_irq    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every decode below sees pre-edge hpos/vpos.
            // The single-cycle strobes default low and are raised only on a tick.
            ce_pix      <= 1'b0;
            frame_start <= 1'b0;
            line_irq    <= 1'b0;

            if (enable) begin
                div <= tick ? '0 : div + 1'b1;
            end

            if (tick) begin
                ce_pix      <= 1'b1;
                hblank      <= hblank_d;
                vblank      <= vblank_d;
                de          <= !hblank_d && !vblank_d;
                hs          <= hs_on ? HS_POL : ~HS_POL;
                vs          <= vs_on ? VS_POL : ~VS_POL;
                h_cnt       <= hpos;
                v_cnt       <= vpos;
                frame_start <= at_origin;
                line_irq    <= (hpos == '0) && (vpos == irq_line);

                // The very first origin after reset is frame 0; later origins count up.
                if (at_origin) begin
                    started <= 1'b1;
                    if (started) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end

                if (hpos == H_LAST_C) begin
                    hpos <= '0;
                    vpos <= (vpos == V_LAST_C) ? '0 : vpos + 1'b1;
                end else begin
                    hpos <= hpos + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two instances (divided active-low, undivided active-high)
// checked every cycle against a pixel-index model, plus directed frame measurements.
`timescale 1ns/1ps
module tb_video_timing_gen;

    // Instance A: CE_DIV=2, active-low syncs, 23 x 13 raster.
    localparam int A_HA = 16, A_HFP = 2, A_HS = 3, A_HBP = 2;
    localparam int A_VA = 6,  A_VFP = 2, A_VS = 2, A_VBP = 3;
    localparam int A_DIV = 2, A_CW = 8;
    // Instance B: CE_DIV=1, active-high syncs, 12 x 7 raster.
    localparam int B_HA = 8,  B_HFP = 1, B_HS = 2, B_HBP = 1;
    localparam int B_VA = 4,  B_VFP = 1, B_VS = 1, B_VBP = 1;
    localparam int B_DIV = 1, B_CW = 4;

    typedef struct packed {
        logic        ce;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        de;
        logic        fs;
        logic        li;
        logic [15:0] h;
        logic [15:0] v;
        logic [7:0]  fc;
    } px_t;

    logic clk;
    logic reset_n;
    logic en_a, en_b;
    logic [A_CW-1:0] irq_a;
    logic [B_CW-1:0] irq_b;

    logic ce_a, hs_a, vs_a, hb_a, vb_a, de_a, fs_a, li_a;
    logic [A_CW-1:0] h_a, v_a;
    logic [7:0] fc_a;
    logic ce_b, hs_b, vs_b, hb_b, vb_b, de_b, fs_b, li_b;
    logic [B_CW-1:0] h_b, v_b;
    logic [7:0] fc_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    video_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CE_DIV(A_DIV), .CW(A_CW)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en_a), .irq_line(irq_a),
        .ce_pix(ce_a), .hs(hs_a), .vs(vs_a), .hblank(hb_a), .vblank(vb_a), .de(de_a),
        .h_cnt(h_a), .v_cnt(v_a), .frame_start(fs_a), .line_irq(li_a), .frame_cnt(fc_a)
    );

    video_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CE_DIV(B_DIV), .CW(B_CW)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(en_b), .irq_line(irq_b),
        .ce_pix(ce_b), .hs(hs_b), .vs(vs_b), .hblank(hb_b), .vblank(vb_b), .de(de_b),
        .h_cnt(h_b), .v_cnt(v_b), .frame_start(fs_b), .line_irq(li_b), .frame_cnt(fc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Expected outputs derived from the index of the pixel currently on display
    // (pix < 0 means no pixel emitted since reset).
    function automatic px_t expect_px(input int pix, input bit ce,
                                      input int ha, input int hfp, input int hsw, input int hbp,
                                      input int va, input int vfp, input int vsw, input int vbp,
                                      input bit hpol, input bit vpol, input int irq);
        px_t r;
        int ht, vt, x, y;
        r = '0;
        if (pix < 0) begin
            r.hs = !hpol;
            r.vs = !vpol;
            r.hb = 1'b1;
            r.vb = 1'b1;
            return r;
        end
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        x  = pix % ht;
        y  = (pix / ht) % vt;
        r.ce = ce;
        r.h  = 16'(x);
        r.v  = 16'(y);
        r.hb = (x >= ha);
        r.vb = (y >= va);
        r.de = (x < ha) && (y < va);
        r.hs = (x >= ha + hfp && x < ha + hfp + hsw) ? hpol : !hpol;
        r.vs = (y >= va + vfp && y < va + vfp + vsw) ? vpol : !vpol;
        r.fs = ce && x == 0 && y == 0;
        r.li = ce && x == 0 && y == irq;
        r.fc = 8'((pix / (ht * vt)) % 256);
        return r;
    endfunction

    task automatic cmp_px(input string tag, input px_t act, input px_t exp);
        check({tag, ".ce_pix"},      32'(act.ce), 32'(exp.ce));
        check({tag, ".hs"},          32'(act.hs), 32'(exp.hs));
        check({tag, ".vs"},          32'(act.vs), 32'(exp.vs));
        check({tag, ".hblank"},      32'(act.hb), 32'(exp.hb));
        check({tag, ".vblank"},      32'(act.vb), 32'(exp.vb));
        check({tag, ".de"},          32'(act.de), 32'(exp.de));
        check({tag, ".frame_start"}, 32'(act.fs), 32'(exp.fs));
        check({tag, ".line_irq"},    32'(act.li), 32'(exp.li));
        check({tag, ".h_cnt"},       32'(act.h),  32'(exp.h));
        check({tag, ".v_cnt"},       32'(act.v),  32'(exp.v));
        check({tag, ".frame_cnt"},   32'(act.fc), 32'(exp.fc));
    endtask

    // Model state: count enabled clk edges; every CE_DIV-th one shows the next pixel.
    int en_cnt_a, pix_a, irq_s_a, en_cnt_b, pix_b, irq_s_b;
    bit ce_m_a, ce_m_b;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_cnt_a <= 0; pix_a <= -1; ce_m_a <= 1'b0; irq_s_a <= 0;
            en_cnt_b <= 0; pix_b <= -1; ce_m_b <= 1'b0; irq_s_b <= 0;
        end else begin
            ce_m_a <= 1'b0;
            ce_m_b <= 1'b0;
            if (en_a) begin
                en_cnt_a <= en_cnt_a + 1;
                if ((en_cnt_a + 1) % A_DIV == 0) begin
                    pix_a <= pix_a + 1; ce_m_a <= 1'b1; irq_s_a <= int'(irq_a);
                end
            end
            if (en_b) begin
                en_cnt_b <= en_cnt_b + 1;
                if ((en_cnt_b + 1) % B_DIV == 0) begin
                    pix_b <= pix_b + 1; ce_m_b <= 1'b1; irq_s_b <= int'(irq_b);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        cmp_px("a", '{ce: ce_a, hs: hs_a, vs: vs_a, hb: hb_a, vb: vb_a, de: de_a, fs: fs_a,
                      li: li_a, h: 16'(h_a), v: 16'(v_a), fc: fc_a},
               expect_px(pix_a, ce_m_a, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP,
                         1'b0, 1'b0, irq_s_a));
        cmp_px("b", '{ce: ce_b, hs: hs_b, vs: vs_b, hb: hb_b, vb: vb_b, de: de_b, fs: fs_b,
                      li: li_b, h: 16'(h_b), v: 16'(v_b), fc: fc_b},
               expect_px(pix_b, ce_m_b, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP,
                         1'b1, 1'b1, irq_s_b));
    end

    task automatic wait_fs(input bit sel_b, output int t);
        bit ok;
        ok = 1'b0;
        t  = cyc;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (sel_b ? fs_b : fs_a) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
        check(sel_b ? "wait_fs_b" : "wait_fs_a", 32'(ok), 32'd1);
    endtask

    // One frame of instance A, optionally pausing at (ph,pv) or changing irq at line cv.
    task automatic measure_a(input int ph, input int pv, input int cv, input int cirq,
                             output int clks, output int de_n, output int hsl_n,
                             output int vsl_n, output int irq_n, output int fc0);
        int t0;
        bit ok, want_next;
        wait_fs(1'b0, t0);
        fc0   = int'(fc_a);
        de_n  = int'(de_a);
        hsl_n = int'(!hs_a);
        vsl_n = int'(!vs_a);
        irq_n = int'(li_a);
        ok = 1'b0;
        want_next = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (fs_a) begin
                ok = 1'b1;
                break;
            end
            if (ce_a) begin
                de_n  += int'(de_a);
                hsl_n += int'(!hs_a);
                vsl_n += int'(!vs_a);
                irq_n += int'(li_a);
                if (want_next) begin
                    check("resume_next_h", 32'(h_a), 32'(ph + 1));
                    want_next = 1'b0;
                end
                if (int'(h_a) == ph && int'(v_a) == pv) begin
                    @(negedge clk) en_a = 1'b0;
                    @(posedge clk); #1;
                    check("pause_ce_low", 32'(ce_a), 32'd0);
                    check("pause_h_hold", 32'(h_a), 32'(ph));
                    repeat (36) @(posedge clk);
                    @(negedge clk) en_a = 1'b1;
                    want_next = 1'b1;
                end
                if (int'(h_a) == 0 && int'(v_a) == cv) begin
                    @(negedge clk) irq_a = A_CW'(cirq);
                end
            end
        end
        check("measure_a_end", 32'(ok), 32'd1);
        clks = cyc - t0;
    endtask

    task automatic measure_b(output int clks, output int hsh_n, output int vsh_n);
        int t0;
        bit ok;
        wait_fs(1'b1, t0);
        hsh_n = int'(hs_b);
        vsh_n = int'(vs_b);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (fs_b) begin
                ok = 1'b1;
                break;
            end
            if (ce_b) begin
                hsh_n += int'(hs_b);
                vsh_n += int'(vs_b);
            end
        end
        check("measure_b_end", 32'(ok), 32'd1);
        clks = cyc - t0;
    endtask

    initial begin
        int clks, de_n, hsl_n, vsl_n, irq_n, fc0, hsh_n, vsh_n;
        bit ok;
        reset_n = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        irq_a = 8'd3;
        irq_b = 4'd6;
        repeat (3) @(negedge clk);
        check("rst_hs_a", 32'(hs_a), 32'd1);
        check("rst_hs_b", 32'(hs_b), 32'd0);
        check("rst_hblank_a", 32'(hb_a), 32'd1);
        check("rst_de_a", 32'(de_a), 32'd0);

        // Release: first pixel of A appears after the 2nd edge, B after the 1st.
        @(negedge clk);
        reset_n = 1'b1; en_a = 1'b1; en_b = 1'b1;
        @(posedge clk); #1;
        check("first_edge_ce_a", 32'(ce_a), 32'd0);
        check("first_edge_ce_b", 32'(ce_b), 32'd1);
        @(posedge clk); #1;
        check("second_edge_ce_a", 32'(ce_a), 32'd1);
        check("first_px_h", 32'(h_a), 32'd0);
        check("first_px_v", 32'(v_a), 32'd0);
        check("first_px_fs", 32'(fs_a), 32'd1);
        check("first_px_de", 32'(de_a), 32'd1);
        check("first_px_fc", 32'(fc_a), 32'd0);

        // Free-running frame of A: 23*13 pixels at 2 clk each.
        measure_a(-1, -1, -1, 0, clks, de_n, hsl_n, vsl_n, irq_n, fc0);
        check("a_second_frame_fc", 32'(fc0), 32'd1);
        check("a_frame_clks", 32'(clks), 32'd598);
        check("a_de_per_frame", 32'(de_n), 32'd96);
        check("a_hs_low_px", 32'(hsl_n), 32'd39);
        check("a_vs_low_px", 32'(vsl_n), 32'd46);
        check("a_irq3_count", 32'(irq_n), 32'd1);

        measure_b(clks, hsh_n, vsh_n);
        check("b_frame_clks", 32'(clks), 32'd84);
        check("b_hs_high_px", 32'(hsh_n), 32'd14);
        check("b_vs_high_px", 32'(vsh_n), 32'd12);

        // irq_line boundaries: past the last line never fires, the last line fires once.
        @(negedge clk) irq_a = 8'd13;
        measure_a(-1, -1, -1, 0, clks, de_n, hsl_n, vsl_n, irq_n, fc0);
        check("a_irq13_count", 32'(irq_n), 32'd0);
        @(negedge clk) irq_a = 8'd12;
        measure_a(-1, -1, -1, 0, clks, de_n, hsl_n, vsl_n, irq_n, fc0);
        check("a_irq12_count", 32'(irq_n), 32'd1);

        // Retarget to an already-passed line mid-frame: nothing fires this frame.
        @(negedge clk) irq_a = 8'd9;
        measure_a(-1, -1, 5, 2, clks, de_n, hsl_n, vsl_n, irq_n, fc0);
        check("a_irq_retarget_count", 32'(irq_n), 32'd0);

        // 37-clk pause inside active video stretches the frame by exactly 37 clk.
        measure_a(10, 2, -1, 0, clks, de_n, hsl_n, vsl_n, irq_n, fc0);
        check("a_paused_frame_clks", 32'(clks), 32'd635);
        check("a_paused_de_count", 32'(de_n), 32'd96);

        // Asynchronous reset in the middle of active video, away from any clk edge.
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (ce_a && de_a && h_a == 8'd5 && v_a == 8'd1) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_mid_active", 32'(ok), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_ce", 32'(ce_a), 32'd0);
        check("async_rst_hs", 32'(hs_a), 32'd1);
        check("async_rst_vs", 32'(vs_a), 32'd1);
        check("async_rst_hblank", 32'(hb_a), 32'd1);
        check("async_rst_vblank", 32'(vb_a), 32'd1);
        check("async_rst_de", 32'(de_a), 32'd0);
        check("async_rst_h", 32'(h_a), 32'd0);
        check("async_rst_v", 32'(v_a), 32'd0);
        check("async_rst_fc", 32'(fc_a), 32'd0);
        check("async_rst_vs_b", 32'(vs_b), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("restart_edge1_ce", 32'(ce_a), 32'd0);
        @(posedge clk); #1;
        check("restart_edge2_ce", 32'(ce_a), 32'd1);
        check("restart_fs", 32'(fs_a), 32'd1);
        check("restart_h", 32'(h_a), 32'd0);

        // Frame counter wrap on B: 255 -> 0.
        ok = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk); #1;
            if (fs_b && fc_b == 8'd255) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_fc_255", 32'(ok), 32'd1);
        wait_fs(1'b1, fc0);
        check("fc_wrap_zero", 32'(fc_b), 32'd0);

        repeat (4) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
